// File: rtl/rv32i_types.sv
// Shared types for the checkpointed register file / rename status table.
package rv32i_types;

    localparam int RF_XLEN     = 32;
    localparam int RF_ROB_W    = 4;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_CKPT = 4;
    localparam int CKPT_W      = $clog2(RF_NUM_CKPT);

    typedef struct packed {
        logic [RF_XLEN-1:0]  reg_value;
        logic                ROB_busy;
        logic [RF_ROB_W-1:0] ROB_idx;
    } rf_entry_t;

    typedef struct packed {
        logic                busy;
        logic [RF_ROB_W-1:0] idx;
    } RegState_t;

endpackage

// File: rtl/rf_ckpt_bank.sv
// Branch checkpoint storage: rename snapshots, slot valid bits,
// per-slot mask of older slots and lowest-free-slot selection.
module rf_ckpt_bank
    import rv32i_types::*;
#(
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int NUM_CKPT  = RF_NUM_CKPT,
    parameter int ROB_IDX_W = RF_ROB_W,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  RegState_t            snap_in [NUM_REGS],
    input  logic                 commit_hit,
    input  logic [REG_W-1:0]     rd_commit,
    input  logic [ROB_IDX_W-1:0] rob_idx_commit,
    input  logic                 resolve_valid,
    input  logic                 resolve_mispredict,
    input  logic [TAG_W-1:0]     resolve_tag,
    output logic [TAG_W-1:0]     free_tag,
    output logic                 full,
    output logic                 tag_ok,
    output RegState_t            restore [NUM_REGS]
);

    logic [NUM_CKPT-1:0] valid_q;
    logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
    RegState_t           snap_q  [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] free_bit;
    logic                res_ok;
    logic                kill;

    assign full   = &valid_q;
    assign tag_ok = valid_q[resolve_tag];
    assign res_ok = resolve_valid && tag_ok;
    assign kill   = res_ok && resolve_mispredict;

    // A slot freed this cycle must not look older than a new slot.
    assign free_bit = (res_ok && !resolve_mispredict)
                    ? (NUM_CKPT'(1) << resolve_tag) : '0;

    always_comb begin
        free_tag = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_tag = TAG_W'(i);
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            restore[r] = snap_q[resolve_tag][r];
        end
        if (commit_hit &&
            snap_q[resolve_tag][rd_commit].idx == rob_idx_commit) begin
            restore[rd_commit].busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                older_q[s] <= '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap_q[s][r] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                if (valid_q[s] && commit_hit &&
                    snap_q[s][rd_commit].idx == rob_idx_commit) begin
                    snap_q[s][rd_commit].busy <= 1'b0;
                end
            end
            if (kill) begin
                for (int s = 0; s < NUM_CKPT; s++) begin
                    if (TAG_W'(s) == resolve_tag ||
                        older_q[s][resolve_tag]) begin
                        valid_q[s] <= 1'b0;
                    end
                end
            end else if (res_ok) begin
                valid_q[resolve_tag] <= 1'b0;
                for (int s = 0; s < NUM_CKPT; s++) begin
                    older_q[s][resolve_tag] <= 1'b0;
                end
            end
            if (alloc && !kill) begin
                valid_q[free_tag] <= 1'b1;
                older_q[free_tag] <= valid_q & ~free_bit;
                for (int r = 0; r < NUM_REGS; r++) begin
                    snap_q[free_tag][r] <= snap_in[r];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_ckpt.sv
// Committed register file with live rename status and
// multi-checkpoint branch recovery.
module regfile_ckpt
    import rv32i_types::*;
#(
    parameter int NUM_REGS  = RF_NUM_REGS,
    parameter int XLEN      = RF_XLEN,
    parameter int ROB_IDX_W = RF_ROB_W,
    parameter int NUM_CKPT  = RF_NUM_CKPT,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int TAG_W    = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch_valid,
    input  logic [REG_W-1:0]     rd_dis,
    input  logic [ROB_IDX_W-1:0] rob_idx_dis,
    input  logic                 br_alloc,
    output logic [TAG_W-1:0]     br_tag_alloc,
    output logic                 ckpt_full,
    input  logic                 commit_valid,
    input  logic [REG_W-1:0]     rd_commit,
    input  logic [ROB_IDX_W-1:0] rob_idx_commit,
    input  logic [XLEN-1:0]      value_commit,
    input  logic                 resolve_valid,
    input  logic [TAG_W-1:0]     resolve_tag,
    input  logic                 resolve_mispredict,
    input  logic [REG_W-1:0]     rs1_s,
    input  logic [REG_W-1:0]     rs2_s,
    output rf_entry_t            rs1_v,
    output rf_entry_t            rs2_v,
    input  logic [REG_W-1:0]     rvfi_rs1_s,
    input  logic [REG_W-1:0]     rvfi_rs2_s,
    output logic [XLEN-1:0]      rvfi_rs1_v,
    output logic [XLEN-1:0]      rvfi_rs2_v
);

    logic [XLEN-1:0] value_q [NUM_REGS];
    RegState_t       live_q  [NUM_REGS];
    RegState_t       live_n  [NUM_REGS];
    RegState_t       restore [NUM_REGS];
    logic            commit_hit;
    logic            disp_hit;
    logic            tag_ok;
    logic            kill;

    assign commit_hit = commit_valid && rd_commit != '0;
    assign disp_hit   = dispatch_valid && rd_dis != '0;
    assign kill       = resolve_valid && resolve_mispredict && tag_ok;

    rf_ckpt_bank #(
        .NUM_REGS  (NUM_REGS),
        .NUM_CKPT  (NUM_CKPT),
        .ROB_IDX_W (ROB_IDX_W)
    ) u_bank (
        .clk                (clk),
        .rst                (rst),
        .alloc              (br_alloc && !ckpt_full),
        .snap_in            (live_n),
        .commit_hit         (commit_hit),
        .rd_commit          (rd_commit),
        .rob_idx_commit     (rob_idx_commit),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .resolve_tag        (resolve_tag),
        .free_tag           (br_tag_alloc),
        .full               (ckpt_full),
        .tag_ok             (tag_ok),
        .restore            (restore)
    );

    // Order matters: commit clear, then dispatch, then recovery.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            live_n[r] = live_q[r];
        end
        if (commit_hit && live_q[rd_commit].idx == rob_idx_commit) begin
            live_n[rd_commit].busy = 1'b0;
        end
        if (disp_hit) begin
            live_n[rd_dis].busy = 1'b1;
            live_n[rd_dis].idx  = rob_idx_dis;
        end
        if (kill) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                live_n[r] = restore[r];
            end
        end
        live_n[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                live_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                live_q[r] <= live_n[r];
            end
            if (commit_hit) value_q[rd_commit] <= value_commit;
            assert (!(br_alloc && ckpt_full))
                else $warning("br_alloc while ckpt_full ignored");
            assert (!(resolve_valid && !tag_ok))
                else $warning("resolve of inactive tag ignored");
        end
    end

    always_comb begin
        rs1_v = '0;
        rs2_v = '0;
        if (rs1_s != '0) begin
            rs1_v.reg_value = (commit_valid && rd_commit == rs1_s)
                            ? value_commit : value_q[rs1_s];
            rs1_v.ROB_busy  = live_q[rs1_s].busy &&
                              !(commit_valid && rd_commit == rs1_s &&
                                live_q[rs1_s].idx == rob_idx_commit);
            rs1_v.ROB_idx   = live_q[rs1_s].idx;
        end
        if (rs2_s != '0) begin
            rs2_v.reg_value = (commit_valid && rd_commit == rs2_s)
                            ? value_commit : value_q[rs2_s];
            rs2_v.ROB_busy  = live_q[rs2_s].busy &&
                              !(commit_valid && rd_commit == rs2_s &&
                                live_q[rs2_s].idx == rob_idx_commit);
            rs2_v.ROB_idx   = live_q[rs2_s].idx;
        end
    end

    assign rvfi_rs1_v = value_q[rvfi_rs1_s];
    assign rvfi_rs2_v = value_q[rvfi_rs2_s];

endmodule

// File: tb/tb_regfile_ckpt.sv
// Bench for regfile_ckpt: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_regfile_ckpt;
    import rv32i_types::*;

    localparam int NR = 32;
    localparam int NC = 4;
    localparam int RW = 4;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          dispatch_valid;
    logic [4:0]    rd_dis;
    logic [RW-1:0] rob_idx_dis;
    logic          br_alloc;
    logic [1:0]    br_tag_alloc;
    logic          ckpt_full;
    logic          commit_valid;
    logic [4:0]    rd_commit;
    logic [RW-1:0] rob_idx_commit;
    logic [XL-1:0] value_commit;
    logic          resolve_valid;
    logic [1:0]    resolve_tag;
    logic          resolve_mispredict;
    logic [4:0]    rs1_s, rs2_s, rvfi_rs1_s, rvfi_rs2_s;
    rf_entry_t     rs1_v, rs2_v;
    logic [XL-1:0] rvfi_rs1_v, rvfi_rs2_v;

    always #5 clk = ~clk;

    regfile_ckpt dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .rd_dis(rd_dis),
        .rob_idx_dis(rob_idx_dis), .br_alloc(br_alloc),
        .br_tag_alloc(br_tag_alloc), .ckpt_full(ckpt_full),
        .commit_valid(commit_valid), .rd_commit(rd_commit),
        .rob_idx_commit(rob_idx_commit), .value_commit(value_commit),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_v(rs1_v), .rs2_v(rs2_v),
        .rvfi_rs1_s(rvfi_rs1_s), .rvfi_rs2_s(rvfi_rs2_s),
        .rvfi_rs1_v(rvfi_rs1_v), .rvfi_rs2_v(rvfi_rs2_v)
    );

    typedef struct packed {
        logic [1:0]             tag;
        logic [NR-1:0]          busy;
        logic [NR-1:0][RW-1:0]  idx;
    } ck_t;

    logic [XL-1:0]         mval [NR];
    logic [NR-1:0]         mbusy;
    logic [NR-1:0][RW-1:0] mtag;
    ck_t                   ckq [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    function automatic int qpos(int t);
        for (int i = 0; i < ckq.size(); i++)
            if (int'(ckq[i].tag) == t) return i;
        return -1;
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < NC; t++)
            if (qpos(t) < 0) return t;
        return -1;
    endfunction

    function automatic rf_entry_t exp_read(logic [4:0] r);
        rf_entry_t e;
        logic byp;
        e = '0;
        if (r != 0) begin
            byp = commit_valid && rd_commit == r;
            e.reg_value = byp ? value_commit : mval[r];
            e.ROB_busy  = mbusy[r] && !(byp && mtag[r] == rob_idx_commit);
            e.ROB_idx   = mtag[r];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) mval[r] = '0;
        mbusy = '0;
        mtag  = '0;
        ckq.delete();
    endtask

    task automatic check();
        bit full_e;
        full_e = ckq.size() == NC;
        cmp("ckpt_full", 64'(ckpt_full), 64'(full_e));
        if (br_alloc && !full_e)
            cmp("br_tag_alloc", 64'(br_tag_alloc), 64'(lowest_free()));
        cmp("rs1_v", 64'(rs1_v), 64'(exp_read(rs1_s)));
        cmp("rs2_v", 64'(rs2_v), 64'(exp_read(rs2_s)));
        cmp("rvfi_rs1_v", 64'(rvfi_rs1_v), 64'(mval[rvfi_rs1_s]));
        cmp("rvfi_rs2_v", 64'(rvfi_rs2_v), 64'(mval[rvfi_rs2_s]));
    endtask

    task automatic model_step();
        logic [NR-1:0]         nb;
        logic [NR-1:0][RW-1:0] nt;
        int  pos, newt;
        bit  full_e, mis, cv;
        ck_t c;
        if (rst) begin
            model_reset();
            return;
        end
        full_e = ckq.size() == NC;
        newt   = lowest_free();
        pos    = resolve_valid ? qpos(int'(resolve_tag)) : -1;
        mis    = pos >= 0 && resolve_mispredict;
        cv     = commit_valid && rd_commit != 0;
        nb = mbusy;
        nt = mtag;
        if (cv && mtag[rd_commit] == rob_idx_commit) nb[rd_commit] = 1'b0;
        if (dispatch_valid && rd_dis != 0 && !mis) begin
            nb[rd_dis] = 1'b1;
            nt[rd_dis] = rob_idx_dis;
        end
        if (cv) begin
            for (int i = 0; i < ckq.size(); i++) begin
                c = ckq[i];
                if (c.idx[rd_commit] == rob_idx_commit) c.busy[rd_commit] = 0;
                ckq[i] = c;
            end
        end
        if (mis) begin
            nb = ckq[pos].busy;
            nt = ckq[pos].idx;
            while (ckq.size() > pos) void'(ckq.pop_back());
        end else begin
            if (pos >= 0) ckq.delete(pos);
            if (br_alloc && !full_e) begin
                c.tag  = 2'(newt);
                c.busy = nb;
                c.idx  = nt;
                ckq.push_back(c);
            end
        end
        mbusy = nb;
        mtag  = nt;
        if (cv) mval[rd_commit] = value_commit;
    endtask

    task automatic step();
        #2;
        check();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        dispatch_valid = 0; rd_dis = 0; rob_idx_dis = 0; br_alloc = 0;
        commit_valid = 0; rd_commit = 0; rob_idx_commit = 0;
        value_commit = 0; resolve_valid = 0; resolve_tag = 0;
        resolve_mispredict = 0;
    endtask

    task automatic disp(int r, int idx);
        idle(); dispatch_valid = 1; rd_dis = 5'(r); rob_idx_dis = 4'(idx);
    endtask

    task automatic comm(int r, int idx, logic [31:0] v);
        idle(); commit_valid = 1; rd_commit = 5'(r);
        rob_idx_commit = 4'(idx); value_commit = v;
    endtask

    task automatic resolve(int t, bit mis);
        idle(); resolve_valid = 1; resolve_tag = 2'(t);
        resolve_mispredict = mis;
    endtask

    initial begin
        idle();
        rs1_s = 5; rs2_s = 6; rvfi_rs1_s = 5; rvfi_rs2_s = 6;
        rst = 1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 0;

        #1;
        cmp("reset_x5", 64'(rs1_v), 64'h0);
        cmp("reset_full", 64'(ckpt_full), 64'h0);
        cmp("reset_tag", 64'(br_tag_alloc), 64'h0);
        step();

        disp(5, 3); step();
        comm(5, 3, 32'hDEAD);
        #1;
        cmp("byp_x5", 64'(rs1_v), {27'h0, 32'hDEAD, 1'b0, 4'd3});
        cmp("model_byp", 64'(exp_read(5)), {27'h0, 32'hDEAD, 1'b0, 4'd3});
        step();
        idle(); #1;
        cmp("x5_after", 64'(rs1_v), {27'h0, 32'hDEAD, 1'b0, 4'd3});
        cmp("rvfi_x5", 64'(rvfi_rs1_v), 64'hDEAD);
        step();

        disp(5, 3); step();
        disp(5, 7); step();
        comm(5, 3, 32'h11); step();
        idle(); #1;
        cmp("stale_commit", 64'(rs1_v), {27'h0, 32'h11, 1'b1, 4'd7});
        step();

        disp(6, 2); step();
        idle(); br_alloc = 1; #1;
        cmp("alloc_t0", 64'(br_tag_alloc), 64'h0);
        step();
        disp(6, 4); step();
        comm(6, 2, 32'h22); step();
        resolve(0, 1); step();
        idle(); #1;
        cmp("restore_x6", 64'(rs2_v), {27'h0, 32'h22, 1'b0, 4'd2});
        cmp("model_x6", 64'(exp_read(6)), {27'h0, 32'h22, 1'b0, 4'd2});
        step();

        for (int i = 0; i < NC; i++) begin
            idle(); br_alloc = 1; #1;
            cmp("alloc_seq", 64'(br_tag_alloc), 64'(i));
            step();
        end
        idle(); br_alloc = 1; #1;
        cmp("full4", 64'(ckpt_full), 64'h1);
        step();
        resolve(1, 1); #1;
        cmp("still_full", 64'(ckpt_full), 64'h1);
        step();
        idle(); br_alloc = 1; #1;
        cmp("unfull", 64'(ckpt_full), 64'h0);
        cmp("realloc_t1", 64'(br_tag_alloc), 64'h1);
        step();
        idle(); br_alloc = 1; step();
        idle(); br_alloc = 1; step();
        resolve(0, 0); br_alloc = 1; #1;
        cmp("full_free", 64'(ckpt_full), 64'h1);
        step();
        idle(); br_alloc = 1; #1;
        cmp("after_free_full", 64'(ckpt_full), 64'h0);
        cmp("after_free_t0", 64'(br_tag_alloc), 64'h0);
        step();

        for (int n = 0; n < 4000; n++) begin
            idle();
            rst = ($urandom_range(0, 599) == 0);
            dispatch_valid = $urandom_range(0, 1);
            rd_dis = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                 : 5'($urandom_range(0, 7));
            rob_idx_dis = 4'($urandom);
            br_alloc = ($urandom_range(0, 3) == 0);
            commit_valid = $urandom_range(0, 1);
            rd_commit = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                                    : 5'($urandom_range(0, 7));
            rob_idx_commit = $urandom_range(0, 1) ? mtag[rd_commit]
                                                  : 4'($urandom);
            value_commit = $urandom;
            if (ckq.size() > 0 && $urandom_range(0, 2) == 0) begin
                resolve_valid = 1;
                resolve_tag = ckq[$urandom_range(0, ckq.size() - 1)].tag;
                resolve_mispredict = $urandom_range(0, 1);
            end
            rs1_s = $urandom_range(0, 1) ? rd_commit : 5'($urandom);
            rs2_s = $urandom_range(0, 1) ? rd_dis : 5'($urandom_range(0, 7));
            rvfi_rs1_s = 5'($urandom_range(0, 7));
            rvfi_rs2_s = 5'($urandom);
            step();
        end
        rst = 0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_ckpt.md
Name: regfile_ckpt

Overview:
- Parametrised successor of the single-snapshot architectural register file / register status table.
- Holds committed register values plus per-register busy/ROB-tag rename state.
- Supports NUM_CKPT concurrent branch checkpoints, selected by branch tag, with selective mispredict recovery that also squashes younger checkpoints.
- Sits between dispatch (rename lookup and tag write), ROB commit (value writeback) and branch resolution (checkpoint free or restore).

Parameters:
NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
XLEN, 32, register value width.
ROB_IDX_W, 4, ROB index width.
NUM_CKPT, 4, number of branch checkpoints; branch tag width is CKPT_W = $clog2(NUM_CKPT).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
dispatch_valid  in  1  dispatch of an instruction writing rd_dis.
rd_dis  in  $clog2(NUM_REGS)  dispatch destination register.
rob_idx_dis  in  ROB_IDX_W  ROB entry of the dispatching instruction.
br_alloc  in  1  dispatching instruction is a branch/jump; take a checkpoint.
br_tag_alloc  out  CKPT_W  tag granted this cycle (valid when br_alloc && !ckpt_full).
ckpt_full  out  1  no free checkpoint; dispatch must stall branches.
commit_valid  in  1  ROB commit with register write.
rd_commit  in  $clog2(NUM_REGS)  commit destination.
rob_idx_commit  in  ROB_IDX_W  committing ROB index.
value_commit  in  XLEN  committed value.
resolve_valid  in  1  branch resolved.
resolve_tag  in  CKPT_W  tag of the resolved branch.
resolve_mispredict  in  1  1 = restore checkpoint; 0 = free it.
rs1_s, rs2_s  in  $clog2(NUM_REGS)  source select.
rs1_v, rs2_v  out  rf_entry_t  {value, busy, rob_idx} for each source.
rvfi_rs1_s, rvfi_rs2_s  in  $clog2(NUM_REGS)  RVFI read select.
rvfi_rs1_v, rvfi_rs2_v  out  XLEN  raw committed value, no bypass.

Behaviour:
- Reset (1 cycle): all values, busy and tags are 0; all checkpoints invalid; ckpt_full=0; br_tag_alloc=0.
- Register 0: never written and never busy; reads return all zeros.
- Dispatch, when dispatch_valid and rd_dis!=0: busy[rd_dis]<=1 and tag[rd_dis]<=rob_idx_dis.
- Commit, when commit_valid and rd_commit!=0:
  - value[rd_commit]<=value_commit unconditionally.
  - Live busy is cleared only if tag[rd_commit]==rob_idx_commit.
  - Same cycle, same register as a dispatch: the dispatch's busy/tag wins and the value is still written.
- Checkpoint commit update: in every valid checkpoint whose entry for rd_commit has a matching tag, that entry's busy is cleared the same cycle.
- Checkpoint allocation, when br_alloc and !ckpt_full:
  - Allocate the lowest free slot; br_tag_alloc shows its index combinationally in the same cycle.
  - The snapshot is the live busy/tag next-state, including same-cycle dispatch and commit effects.
  - The slot's older_mask is set to the valid-slot vector of that cycle.
- br_alloc while full: ignored with no state change; a simulation assertion fires.
- ckpt_full = all slots valid, registered-state based.
  - A free in the same cycle does not unblock allocation until the next cycle.
- Correct resolve: slot resolve_tag becomes invalid and bit resolve_tag is cleared in every older_mask.
- Mispredict resolve:
  - Live busy/tag for all registers <= checkpoint[resolve_tag] with the same-cycle commit busy-clear applied.
  - resolve_tag and every slot j with older_mask[j][resolve_tag]=1 (younger) are invalidated.
  - Same-cycle dispatch and br_alloc are discarded.
  - Values are never restored.
- Resolve of an invalid tag: no effect; an assertion fires.
- Read ports are combinational:
  - value bypasses the same-cycle commit when rs==rd_commit.
  - busy reads 0 if the same-cycle commit matches that register's live tag.
  - Dispatch is not bypassed to reads.
- RVFI ports: raw stored value only.
- Reset mid-operation: dominates all inputs.

Decomposition:
- Package rv32i_types gains rf_entry_t {reg_value, ROB_busy, ROB_idx}, RegState_t {busy, idx} and localparams for CKPT_W.
- Sub-module rf_ckpt_bank: NUM_CKPT snapshot arrays, valid bits, older_mask matrix, free-slot priority encoder.
- The top level holds the live table, read/bypass logic and next-state merge.

Test Plan:
- Reset, then read x5 -> value 0, busy 0; ckpt_full=0.
- Dispatch x5 rob 3; commit x5 rob 3 value 0xDEAD next cycle.
  - Required: x5 busy 0, value 0xDEAD.
  - Same-cycle read of x5 at commit returns 0xDEAD and busy 0.
- Dispatch x5 rob 3, then x5 rob 7; commit rob 3 value 0x11.
  - Required: value 0x11, busy stays 1, tag 7.
- br_alloc (tag 0) after x6 is dispatched to rob 2; dispatch x6 rob 4; commit rob 2; mispredict tag 0.
  - Required: x6 busy 0, tag 2.
- Allocate tags 0,1,2,3 -> ckpt_full=1 and a 5th br_alloc is ignored; mispredict tag 1.
  - Required: slots 1,2,3 freed, slot 0 valid, ckpt_full=0, next alloc returns tag 1.
- Correct resolve of tag 0 with simultaneous br_alloc while full.
  - Required: allocation rejected that cycle; next cycle allocation returns tag 0.
